// File: rtl/ppu_cpu_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_cpu_if_pkg
//  Description : Shared constants for the PPU CPU-side register window:
//                register indices, chip-select decode, status bit positions
//                and CPU bus read/write polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
package ppu_cpu_if_pkg;

  // Register index within the 8-byte mirrored window ($2000 + a[2:0])
  localparam logic [2:0] c_reg_ctrl     = 3'd0;
  localparam logic [2:0] c_reg_mask     = 3'd1;
  localparam logic [2:0] c_reg_status   = 3'd2;
  localparam logic [2:0] c_reg_oam_addr = 3'd3;
  localparam logic [2:0] c_reg_oam_data = 3'd4;
  localparam logic [2:0] c_reg_scroll   = 3'd5;
  localparam logic [2:0] c_reg_addr     = 3'd6;
  localparam logic [2:0] c_reg_data     = 3'd7;

  // a[15:13] value selecting the $2000-$3FFF window
  localparam logic [2:0] c_cs_decode = 3'b001;

  // CPU bus rw polarity: 1 = read, 0 = write
  localparam logic c_rw_read = 1'b1;

  // PPUSTATUS bit positions
  localparam int c_stat_vblank = 7;
  localparam int c_stat_spr0   = 6;
  localparam int c_stat_ovf    = 5;

  // Status byte: flags in the top three bits, open-bus bits below
  function automatic logic [7:0] status_byte(input logic       vb,
                                             input logic       s0,
                                             input logic       ov,
                                             input logic [7:0] io);
    logic [7:0] b;
    b                = io;
    b[c_stat_vblank] = vb;
    b[c_stat_spr0]   = s0;
    b[c_stat_ovf]    = ov;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_cpu_if_scroll_regs.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_cpu_if_scroll_regs
//  Description : Scroll/address latches t, v, fine_x and the shared write
//                toggle w, driven by PPUCTRL/PPUSCROLL/PPUADDR writes,
//                PPUDATA increments and PPUSTATUS toggle reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_cpu_if_scroll_regs #(
  parameter int INC_WIDE = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        ctrl_wr,
  input  logic        scroll_wr,
  input  logic        addr_wr,
  input  logic        inc_en,
  input  logic        inc_wide,
  input  logic        w_clr,
  output logic [14:0] t,
  output logic [14:0] v,
  output logic [2:0]  fine_x,
  output logic        w
);

  logic [14:0] r_t;
  logic [14:0] r_v;
  logic [2:0]  r_fine_x;
  logic        r_w;
  logic [14:0] w_inc;

  assign w_inc  = inc_wide ? 15'(INC_WIDE) : 15'd1;
  assign t      = r_t;
  assign v      = r_v;
  assign fine_x = r_fine_x;
  assign w      = r_w;

  // Latch updates; at most one register access per cycle so the branches never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t      <= '0;
      r_v      <= '0;
      r_fine_x <= '0;
      r_w      <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        r_t[11:10] <= din[1:0];
      end
      if (scroll_wr) begin
        if (!r_w) begin
          r_t[4:0] <= din[7:3];
          r_fine_x <= din[2:0];
          r_w      <= 1'b1;
        end else begin
          r_t[14:12] <= din[2:0];
          r_t[9:5]   <= din[7:3];
          r_w        <= 1'b0;
        end
      end
      if (addr_wr) begin
        if (!r_w) begin
          r_t[13:8] <= din[5:0];
          r_t[14]   <= 1'b0;
          r_w       <= 1'b1;
        end else begin
          r_t[7:0] <= din;
          r_v      <= {r_t[14:8], din};
          r_w      <= 1'b0;
        end
      end
      if (inc_en) begin
        r_v <= r_v + w_inc;
      end
      if (w_clr) begin
        r_w <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ppu_cpu_if.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_cpu_if
//  Description : CPU-bus responder for the PPU register window $2000-$3FFF.
//                Decodes accesses, holds control/mask/OAM address, status
//                flags, open-bus latch and PPUDATA read buffer; issues
//                single-cycle VRAM/OAM strobes and drives nmi_n.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_cpu_if
  import ppu_cpu_if_pkg::*;
#(
  parameter int INC_WIDE = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        rw,
  output logic        nmi_n,
  output logic [7:0]  ctrl,
  output logic [7:0]  mask,
  output logic [14:0] v,
  output logic [14:0] t,
  output logic [2:0]  fine_x,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_rdata,
  output logic        vram_wr,
  output logic [7:0]  vram_wdata,
  output logic [7:0]  oam_addr,
  input  logic [7:0]  oam_rdata,
  output logic        oam_wr,
  output logic [7:0]  oam_wdata,
  input  logic        vblank_set,
  input  logic        vblank_clr,
  input  logic        spr0_set,
  input  logic        ovf_set
);

  logic [7:0] r_ctrl;
  logic [7:0] r_mask;
  logic [7:0] r_oam_addr;
  logic [7:0] r_rd_buf;
  logic [7:0] r_io_latch;
  logic       r_vblank;
  logic       r_spr0;
  logic       r_ovf;
  logic       r_rd_pend;

  logic       w_cs;
  logic [2:0] w_idx;
  logic       w_rd;
  logic       w_wr;
  logic [7:0] w_rdata;
  logic       w_scroll_w;
  logic       w_unused_addr;

  // Decode; reset gates every strobe and the bus driver so an aborted access has no effect
  assign w_cs          = (a[15:13] == c_cs_decode);
  assign w_idx         = a[2:0];
  assign w_rd          = rst_n & w_cs & (rw == c_rw_read);
  assign w_wr          = rst_n & w_cs & (rw != c_rw_read);
  assign w_unused_addr = ^a[12:3] ^ w_scroll_w;

  assign d          = w_rd ? w_rdata : 8'hzz;
  assign vram_rd    = w_rd & (w_idx == c_reg_data);
  assign vram_wr    = w_wr & (w_idx == c_reg_data);
  assign vram_wdata = d;
  assign vram_addr  = v[13:0];
  assign oam_wr     = w_wr & (w_idx == c_reg_oam_data);
  assign oam_wdata  = d;
  assign oam_addr   = r_oam_addr;
  assign ctrl       = r_ctrl;
  assign mask       = r_mask;
  assign nmi_n      = ~(r_vblank & r_ctrl[7]);

  // Read mux from pre-edge state; a vblank set landing on a status read reads as clear
  always_comb begin
    w_rdata = r_io_latch;
    case (w_idx)
      c_reg_status:   w_rdata = status_byte(r_vblank & ~vblank_set, r_spr0, r_ovf, r_io_latch);
      c_reg_oam_data: w_rdata = oam_rdata;
      c_reg_data:     w_rdata = r_rd_buf;
      default:        w_rdata = r_io_latch;
    endcase
  end

  // Control registers, OAM address, open-bus latch and the delayed PPUDATA buffer fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= '0;
      r_mask     <= '0;
      r_oam_addr <= '0;
      r_io_latch <= '0;
      r_rd_buf   <= '0;
      r_rd_pend  <= 1'b0;
    end else begin
      r_rd_pend <= vram_rd;
      if (r_rd_pend) begin
        r_rd_buf <= vram_rdata;
      end
      if (w_rd) begin
        r_io_latch <= w_rdata;
      end else if (w_wr) begin
        r_io_latch <= d;
      end
      if (w_wr) begin
        case (w_idx)
          c_reg_ctrl:     r_ctrl     <= d;
          c_reg_mask:     r_mask     <= d;
          c_reg_oam_addr: r_oam_addr <= d;
          c_reg_oam_data: r_oam_addr <= r_oam_addr + 8'd1;
          default:        ;
        endcase
      end
    end
  end

  // Status flags: renderer clear wins, then set, then the status-read clear of vblank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblank <= 1'b0;
      r_spr0   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (vblank_clr) begin
        r_vblank <= 1'b0;
      end else if (vblank_set) begin
        r_vblank <= 1'b1;
      end else if (w_rd && (w_idx == c_reg_status)) begin
        r_vblank <= 1'b0;
      end
      if (vblank_clr) begin
        r_spr0 <= 1'b0;
        r_ovf  <= 1'b0;
      end else begin
        if (spr0_set) r_spr0 <= 1'b1;
        if (ovf_set)  r_ovf  <= 1'b1;
      end
    end
  end

  ppu_cpu_if_scroll_regs #(
    .INC_WIDE (INC_WIDE)
  ) u_scroll (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (d),
    .ctrl_wr   (w_wr & (w_idx == c_reg_ctrl)),
    .scroll_wr (w_wr & (w_idx == c_reg_scroll)),
    .addr_wr   (w_wr & (w_idx == c_reg_addr)),
    .inc_en    ((w_rd | w_wr) & (w_idx == c_reg_data)),
    .inc_wide  (r_ctrl[2]),
    .w_clr     (w_rd & (w_idx == c_reg_status)),
    .t         (t),
    .v         (v),
    .fine_x    (fine_x),
    .w         (w_scroll_w)
  );

endmodule
`default_nettype wire

// File: tb/tb_ppu_cpu_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ppu_cpu_if
//  Description : Self-checking bench for ppu_cpu_if: directed scenarios with
//                literal expectations followed by randomized bus traffic,
//                all compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_cpu_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  wire  [7:0]  d;
  logic        rw;
  logic        nmi_n;
  logic [7:0]  ctrl, mask, oam_addr, oam_rdata, oam_wdata, vram_rdata, vram_wdata;
  logic [14:0] v, t;
  logic [2:0]  fine_x;
  logic [13:0] vram_addr;
  logic        vram_rd, vram_wr, oam_wr;
  logic        vblank_set, vblank_clr, spr0_set, ovf_set;

  logic        tb_drv;
  logic [7:0]  tb_dval;
  assign d = tb_drv ? tb_dval : 8'hzz;

  always #5 clk = ~clk;

  ppu_cpu_if #(.INC_WIDE(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .d(d), .rw(rw), .nmi_n(nmi_n),
    .ctrl(ctrl), .mask(mask), .v(v), .t(t), .fine_x(fine_x),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_rdata(vram_rdata),
    .vram_wr(vram_wr), .vram_wdata(vram_wdata), .oam_addr(oam_addr),
    .oam_rdata(oam_rdata), .oam_wr(oam_wr), .oam_wdata(oam_wdata),
    .vblank_set(vblank_set), .vblank_clr(vblank_clr),
    .spr0_set(spr0_set), .ovf_set(ovf_set)
  );

  // Behavioural model state
  logic [7:0]  m_ctrl, m_mask, m_oam, m_buf, m_io;
  logic [14:0] m_t, m_v;
  logic [2:0]  m_fx;
  logic        m_w, m_vb, m_s0, m_ov, m_pend;

  int tests = 0;
  int fails = 0;

  logic       vs_in, vc_in, s0_in, ov_in;
  logic       vrd_fix_en;
  logic [7:0] vrd_fix;

  logic [7:0]  last_d, last_vram_wdata, last_oam_wdata, last_oam_rdata;
  logic [13:0] last_vram_addr;
  logic        last_vram_wr, last_vram_rd, last_oam_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_mask = 0; m_oam = 0; m_buf = 0; m_io = 0;
    m_t = 0; m_v = 0; m_fx = 0; m_w = 0; m_vb = 0; m_s0 = 0; m_ov = 0; m_pend = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd2:    return {m_vb && !vs_in, m_s0, m_ov, m_io[4:0]};
      3'd4:    return oam_rdata;
      3'd7:    return m_buf;
      default: return m_io;
    endcase
  endfunction

  // One bus cycle: drive, compare mid-cycle against the model, advance model at the edge
  task automatic step(input logic sel, input logic [2:0] idx, input logic rdn, input logic [7:0] wd);
    logic [2:0] top;
    logic       rd, wr;
    logic [7:0] exp;
    int         inc;
    if (sel) begin
      a = {3'b001, 10'($urandom), idx};
    end else begin
      top = 3'($urandom_range(0, 6));
      if (top >= 3'd1) top = top + 3'd1;
      a = {top, 13'($urandom)};
    end
    rw = rdn; tb_drv = !rdn; tb_dval = wd;
    vram_rdata = vrd_fix_en ? vrd_fix : 8'($urandom);
    oam_rdata  = 8'($urandom);
    vblank_set = vs_in; vblank_clr = vc_in; spr0_set = s0_in; ovf_set = ov_in;
    #3;
    rd  = sel && rdn;
    wr  = sel && !rdn;
    exp = model_read(idx);
    if (rd) check("d_read", d, exp);
    check("vram_rd", vram_rd, rd && idx == 3'd7);
    check("vram_wr", vram_wr, wr && idx == 3'd7);
    check("oam_wr", oam_wr, wr && idx == 3'd4);
    if (wr && idx == 3'd7) check("vram_wdata", vram_wdata, wd);
    if (wr && idx == 3'd4) check("oam_wdata", oam_wdata, wd);
    check("vram_addr", vram_addr, m_v[13:0]);
    check("nmi_n", nmi_n, !(m_vb && m_ctrl[7]));
    check("ctrl", ctrl, m_ctrl);
    check("mask", mask, m_mask);
    check("t", t, m_t);
    check("v", v, m_v);
    check("fine_x", fine_x, m_fx);
    check("oam_addr", oam_addr, m_oam);
    last_d = d; last_vram_wr = vram_wr; last_vram_rd = vram_rd; last_vram_addr = vram_addr;
    last_vram_wdata = vram_wdata; last_oam_wr = oam_wr; last_oam_wdata = oam_wdata;
    last_oam_rdata = oam_rdata;
    @(posedge clk);
    inc = m_ctrl[2] ? 32 : 1;
    if (m_pend) m_buf = vram_rdata;
    m_pend = rd && idx == 3'd7;
    if (sel) m_io = rd ? exp : wd;
    if (vc_in)                     m_vb = 1'b0;
    else if (vs_in)                m_vb = 1'b1;
    else if (rd && idx == 3'd2)    m_vb = 1'b0;
    if (vc_in) begin
      m_s0 = 1'b0; m_ov = 1'b0;
    end else begin
      if (s0_in) m_s0 = 1'b1;
      if (ov_in) m_ov = 1'b1;
    end
    if (rd && idx == 3'd2) m_w = 1'b0;
    if (sel && idx == 3'd7) m_v = 15'((int'(m_v) + inc) % 32768);
    if (wr) begin
      case (idx)
        3'd0: begin m_ctrl = wd; m_t[11:10] = wd[1:0]; end
        3'd1: m_mask = wd;
        3'd3: m_oam = wd;
        3'd4: m_oam = 8'((int'(m_oam) + 1) % 256);
        3'd5: begin
          if (!m_w) begin m_t[4:0] = wd[7:3]; m_fx = wd[2:0]; m_w = 1'b1; end
          else begin m_t[14:12] = wd[2:0]; m_t[9:5] = wd[7:3]; m_w = 1'b0; end
        end
        3'd6: begin
          if (!m_w) begin m_t[13:8] = wd[5:0]; m_t[14] = 1'b0; m_w = 1'b1; end
          else begin m_t[7:0] = wd; m_v = m_t; m_w = 1'b0; end
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [7:0] val);
    step(1'b1, idx, 1'b0, val);
  endtask
  task automatic rd(input logic [2:0] idx);
    step(1'b1, idx, 1'b1, 8'h00);
  endtask
  task automatic idle();
    step(1'b0, 3'd0, 1'b1, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; a = 16'h2007; rw = 1'b1; tb_drv = 1'b0; tb_dval = 8'h00;
    vram_rdata = 8'h00; oam_rdata = 8'h00;
    vblank_set = 0; vblank_clr = 0; spr0_set = 0; ovf_set = 0;
    vs_in = 0; vc_in = 0; s0_in = 0; ov_in = 0; vrd_fix_en = 0; vrd_fix = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset holds strobes low even with a PPUDATA read on the bus
    check("rst_vram_rd", vram_rd, 1'b0);
    check("rst_nmi_n", nmi_n, 1'b1);
    check("rst_ctrl", ctrl, 8'h00);
    check("rst_v", v, 15'h0000);
    rst_n = 1'b1;

    // Status read after reset
    rd(2);
    check("status_after_reset", last_d, 8'h00);

    // PPUADDR load and PPUDATA write
    wr(6, 8'h21);
    wr(6, 8'h08);
    check("v_after_2006", v, 15'h2108);
    check("t_after_2006", t, 15'h2108);
    wr(7, 8'h5A);
    check("wr_strobe", last_vram_wr, 1'b1);
    check("wr_addr", last_vram_addr, 14'h2108);
    check("wr_data", last_vram_wdata, 8'h5A);
    check("v_after_2007", v, 15'h2109);

    // Wide increment and buffered reads
    wr(0, 8'h04);
    wr(6, 8'h23);
    wr(6, 8'hC0);
    vrd_fix_en = 1'b1; vrd_fix = 8'hAB;
    rd(7);
    check("rd1_addr", last_vram_addr, 14'h23C0);
    check("rd1_data", last_d, 8'h00);
    idle(); idle(); idle();
    vrd_fix_en = 1'b0;
    rd(7);
    check("rd2_data", last_d, 8'hAB);
    check("v_wide", v, 15'h2400);

    // Scroll writes with a status read resetting the toggle in between
    wr(0, 8'h00);
    wr(5, 8'h7D);
    rd(2);
    wr(5, 8'h7D);
    wr(5, 8'h5E);
    check("fine_x", fine_x, 3'd5);
    check("t_coarse_x", t[4:0], 5'd15);
    check("t_coarse_y", t[9:5], 5'd11);
    check("t_fine_y", t[14:12], 3'd6);

    // Vblank / NMI
    vs_in = 1'b1; idle(); vs_in = 1'b0;
    wr(0, 8'h80);
    check("nmi_low", nmi_n, 1'b0);
    rd(2);
    check("status_vb", last_d[7], 1'b1);
    check("nmi_released", nmi_n, 1'b1);
    vs_in = 1'b1; rd(2); vs_in = 1'b0;
    check("status_race", last_d[7], 1'b0);
    check("nmi_after_race", nmi_n, 1'b0);
    vc_in = 1'b1; idle(); vc_in = 1'b0;
    check("nmi_after_clr", nmi_n, 1'b1);

    // OAM address wrap and non-incrementing OAMDATA read
    wr(3, 8'hFF);
    wr(4, 8'h12);
    check("oam_strobe", last_oam_wr, 1'b1);
    check("oam_wdata", last_oam_wdata, 8'h12);
    check("oam_wrap", oam_addr, 8'h00);
    rd(4);
    check("oam_read", last_d, last_oam_rdata);
    check("oam_no_inc", oam_addr, 8'h00);

    // Reset in the middle of a PPUDATA write aborts the strobe and clears state
    a = 16'h2007; rw = 1'b0; tb_drv = 1'b1; tb_dval = 8'h77;
    #2;
    check("pre_rst_strobe", vram_wr, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobe", vram_wr, 1'b0);
    check("mid_rst_v", v, 15'h0000);
    check("mid_rst_ctrl", ctrl, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1; tb_drv = 1'b0; rw = 1'b1;
    model_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      vs_in = ($urandom_range(0, 15) == 0);
      vc_in = ($urandom_range(0, 31) == 0);
      s0_in = ($urandom_range(0, 15) == 0);
      ov_in = ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 8'($urandom));
    end
    vs_in = 0; vc_in = 0; s0_in = 0; ov_in = 0;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
